// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and round-robin arbiter that shares one single-port RAM
// between the SPI slave and a local requester.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 spi_ovf,
    input  logic                 loc_req,
    input  logic                 loc_we,
    input  logic [ADDR_SIZE-1:0] loc_addr,
    input  logic [7:0]           loc_wdata,
    output logic                 loc_gnt,
    output logic                 loc_rvalid,
    output logic [7:0]           loc_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_din,
    input  logic [7:0]           mem_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, RD_RET} state_t;

    state_t               state;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr, pend_addr;
    logic [7:0]           pend_data;
    logic                 pend, pend_we;
    logic                 last_loc, win_loc;
    logic [1:0]           cmd;
    logic [7:0]           payload;
    logic                 spi_ram_cmd, pend_free, grant_spi, grant_loc;

    if (MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_depth_check
        $error("MEM_DEPTH exceeds the range of ADDR_SIZE");
    end

    assign cmd         = rx_data[9:8];
    assign payload     = rx_data[7:0];
    assign spi_ram_cmd = rx_valid & cmd[0];
    // The entry served in this ACCESS cycle can already take a new command.
    assign pend_free   = !pend || (state == ACCESS && !win_loc);

    always_comb begin
        grant_spi = 1'b0;
        grant_loc = 1'b0;
        if (state == IDLE) begin
            if (pend && loc_req) begin
                grant_spi = last_loc;
                grant_loc = !last_loc;
            end else begin
                grant_spi = pend;
                grant_loc = loc_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (spi_ram_cmd && pend_free) begin
            pend_addr <= cmd[1] ? rd_addr : wr_addr;
            pend_data <= payload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_addr    <= '0;
            rd_addr    <= '0;
            pend       <= 1'b0;
            pend_we    <= 1'b0;
            last_loc   <= 1'b1;
            win_loc    <= 1'b0;
            spi_ovf    <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            loc_gnt    <= 1'b0;
            loc_rvalid <= 1'b0;
            loc_rdata  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            loc_gnt    <= 1'b0;
            loc_rvalid <= 1'b0;
            if (rx_valid) begin
                tx_valid <= 1'b0;
                if (cmd == 2'b00) wr_addr <= ADDR_SIZE'(payload);
                if (cmd == 2'b10) rd_addr <= ADDR_SIZE'(payload);
            end
            if (state == ACCESS && !win_loc) pend <= 1'b0;
            if (spi_ram_cmd) begin
                if (pend_free) begin
                    pend    <= 1'b1;
                    pend_we <= !cmd[1];
                end else begin
                    spi_ovf <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (grant_spi) begin
                        mem_en   <= 1'b1;
                        mem_we   <= pend_we;
                        mem_addr <= pend_addr;
                        mem_din  <= pend_data;
                        win_loc  <= 1'b0;
                        last_loc <= 1'b0;
                        state    <= ACCESS;
                    end else if (grant_loc) begin
                        mem_en   <= 1'b1;
                        mem_we   <= loc_we;
                        mem_addr <= loc_addr;
                        mem_din  <= loc_wdata;
                        loc_gnt  <= 1'b1;
                        win_loc  <= 1'b1;
                        last_loc <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= mem_we ? IDLE : RD_RET;
                end
                RD_RET: begin
                    if (win_loc) begin
                        loc_rdata  <= mem_dout;
                        loc_rvalid <= 1'b1;
                    end else begin
                        tx_data  <= mem_dout;
                        tx_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed and randomized bench for spi_ram_arbiter against a timeline-based
// reference model of the arbitration and read-return rules.
module tb_spi_ram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx_valid, tx_valid, spi_ovf;
    logic [9:0] rx_data;
    logic [7:0] tx_data;
    logic       loc_req, loc_we, loc_gnt, loc_rvalid;
    logic [7:0] loc_addr, loc_wdata, loc_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;

    spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .spi_ovf(spi_ovf),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_gnt(loc_gnt), .loc_rvalid(loc_rvalid), .loc_rdata(loc_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Single-port RAM with one-cycle read latency, plus a preload path.
    logic [7:0] ram [256];
    logic       preload;
    logic [7:0] pl_addr, pl_data;
    always @(posedge clk) begin
        if (preload) ram[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic found;

    // Reference model: pending queue, address registers and a timeline of
    // decision / access / return cycle numbers.
    logic [7:0] ref_ram [256];
    logic       m_pv, m_pwe, m_ovf, m_last_loc;
    logic [7:0] m_pa, m_pd, m_wr, m_rd;
    int         next_dec, acc_at, ret_at;
    logic       a_loc, a_we, r_loc;
    logic [7:0] a_addr, a_din, r_data;
    logic       e_en, e_we, e_gnt, e_txv, e_lrv, e_ovf;
    logic [7:0] e_addr, e_din, e_tx, e_lrd;

    task automatic model_step();
        logic take_loc;
        if (!rst_n) begin
            m_pv = 0; m_pwe = 0; m_ovf = 0; m_last_loc = 1;
            m_wr = 0; m_rd = 0;
            next_dec = cyc + 1; acc_at = -100; ret_at = -100;
            e_en = 0; e_we = 0; e_gnt = 0; e_txv = 0; e_lrv = 0; e_ovf = 0;
            e_addr = 0; e_din = 0; e_tx = 0; e_lrd = 0;
            return;
        end
        if (acc_at == cyc && !a_loc) m_pv = 0;
        if (cyc >= next_dec && (m_pv || loc_req)) begin
            take_loc   = loc_req && (!m_pv || !m_last_loc);
            a_loc      = take_loc;
            a_we       = take_loc ? loc_we : m_pwe;
            a_addr     = take_loc ? loc_addr : m_pa;
            a_din      = take_loc ? loc_wdata : m_pd;
            m_last_loc = take_loc;
            acc_at     = cyc + 1;
            if (a_we) begin
                ref_ram[a_addr] = a_din;
                next_dec = cyc + 2;
            end else begin
                r_data   = ref_ram[a_addr];
                r_loc    = take_loc;
                ret_at   = cyc + 3;
                next_dec = cyc + 3;
            end
        end
        if (rx_valid) begin
            e_txv = 0;
            case (rx_data[9:8])
                2'b00: m_wr = rx_data[7:0];
                2'b10: m_rd = rx_data[7:0];
                default: begin
                    if (!m_pv) begin
                        m_pv  = 1;
                        m_pwe = (rx_data[9:8] == 2'b01);
                        m_pa  = m_pwe ? m_wr : m_rd;
                        m_pd  = rx_data[7:0];
                    end else begin
                        m_ovf = 1;
                    end
                end
            endcase
        end
        e_en  = (acc_at == cyc + 1);
        e_we  = e_en && a_we;
        e_gnt = e_en && a_loc;
        if (e_en) begin
            e_addr = a_addr;
            e_din  = a_din;
        end
        e_lrv = 0;
        if (ret_at == cyc + 1) begin
            if (r_loc) begin
                e_lrd = r_data;
                e_lrv = 1;
            end else begin
                e_tx  = r_data;
                e_txv = 1;
            end
        end
        e_ovf = m_ovf;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_model();
        chk1("mem_en", mem_en, e_en);
        chk1("mem_we", mem_we, e_we);
        chk1("loc_gnt", loc_gnt, e_gnt);
        chk1("tx_valid", tx_valid, e_txv);
        chk8("tx_data", tx_data, e_tx);
        chk1("loc_rvalid", loc_rvalid, e_lrv);
        chk8("loc_rdata", loc_rdata, e_lrd);
        chk1("spi_ovf", spi_ovf, e_ovf);
        if (e_en) chk8("mem_addr", mem_addr, e_addr);
        if (e_we) chk8("mem_din", mem_din, e_din);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic spi(input logic [1:0] c, input logic [7:0] p);
        rx_valid = 1'b1;
        rx_data  = {c, p};
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 0; rx_valid = 0; rx_data = 0;
        loc_req = 0; loc_we = 0; loc_addr = 0; loc_wdata = 0;
        preload = 0; pl_addr = 0; pl_data = 0;

        for (int a = 0; a < 256; a++) begin
            preload = 1;
            pl_addr = 8'(a);
            pl_data = 8'($urandom);
            ref_ram[a] = pl_data;
            tick();
        end
        preload = 0;
        tick();
        chk1("reset_mem_en", mem_en, 1'b0);
        chk1("reset_tx_valid", tx_valid, 1'b0);
        chk8("reset_tx_data", tx_data, 8'h00);
        chk1("reset_spi_ovf", spi_ovf, 1'b0);
        chk1("reset_loc_gnt", loc_gnt, 1'b0);
        chk8("reset_mem_addr", mem_addr, 8'h00);
        rst_n = 1;
        tick();

        // SPI write: access two cycles after the 01 strobe.
        spi(2'b00, 8'h12);
        spi(2'b01, 8'hA5);
        tick();
        chk1("t1_mem_en", mem_en, 1'b1);
        chk1("t1_mem_we", mem_we, 1'b1);
        chk8("t1_mem_addr", mem_addr, 8'h12);
        chk8("t1_mem_din", mem_din, 8'hA5);
        tick();
        chk1("t1_mem_en_one_cycle", mem_en, 1'b0);
        idle(2);

        // SPI read of the byte just written.
        spi(2'b10, 8'h12);
        spi(2'b11, 8'h00);
        tick();
        chk1("t2_mem_en", mem_en, 1'b1);
        chk1("t2_mem_we", mem_we, 1'b0);
        chk8("t2_mem_addr", mem_addr, 8'h12);
        idle(2);
        chk1("t2_tx_valid", tx_valid, 1'b1);
        chk8("t2_tx_data", tx_data, 8'hA5);
        idle(3);
        chk1("t2_tx_valid_held", tx_valid, 1'b1);
        spi(2'b00, 8'h00);
        chk1("t2_tx_valid_cleared", tx_valid, 1'b0);
        chk8("t2_tx_data_held", tx_data, 8'hA5);
        idle(2);

        // Contention from reset: SPI wins the first tie, then LOC, then SPI.
        rst_n = 0;
        tick();
        rst_n = 1;
        spi(2'b00, 8'h33);
        spi(2'b01, 8'h5C);
        loc_req = 1; loc_we = 0; loc_addr = 8'h40; loc_wdata = 8'h00;
        tick();
        chk1("t3_spi_first", mem_en, 1'b1);
        chk8("t3_spi_addr", mem_addr, 8'h33);
        chk1("t3_no_gnt", loc_gnt, 1'b0);
        idle(2);
        chk1("t3_loc_gnt", loc_gnt, 1'b1);
        chk8("t3_loc_addr", mem_addr, 8'h40);
        chk1("t3_loc_read", mem_we, 1'b0);
        loc_req = 0;
        idle(2);
        chk1("t3_loc_rvalid", loc_rvalid, 1'b1);
        chk8("t3_loc_rdata", loc_rdata, ref_ram[8'h40]);
        tick();
        chk1("t3_loc_rvalid_pulse", loc_rvalid, 1'b0);
        spi(2'b01, 8'h11);
        loc_req = 1; loc_we = 1; loc_addr = 8'h41; loc_wdata = 8'h66;
        tick();
        chk1("t3_tie2_spi", mem_en, 1'b1);
        chk1("t3_tie2_no_gnt", loc_gnt, 1'b0);
        chk8("t3_tie2_din", mem_din, 8'h11);
        idle(2);
        chk1("t3_tie2_loc_gnt", loc_gnt, 1'b1);
        loc_req = 0;
        idle(3);

        // Overflow: second back-to-back SPI write is dropped.
        loc_req = 1; loc_we = 1; loc_addr = 8'h50; loc_wdata = 8'h99;
        spi(2'b00, 8'h20);
        spi(2'b01, 8'h01);
        spi(2'b01, 8'h02);
        chk1("t4_ovf_set", spi_ovf, 1'b1);
        found = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_en && mem_we && mem_addr == 8'h20 && mem_din == 8'h01) found = 1;
            tick();
        end
        chk1("t4_first_served", found, 1'b1);
        loc_req = 0;
        idle(4);
        chk1("t4_ovf_sticky", spi_ovf, 1'b1);
        rst_n = 0;
        tick();
        chk1("t4_ovf_reset", spi_ovf, 1'b0);
        rst_n = 1;
        tick();

        // Address isolation: address captured at enqueue.
        spi(2'b00, 8'h05);
        spi(2'b01, 8'h3C);
        spi(2'b00, 8'h07);
        chk1("t5_mem_en", mem_en, 1'b1);
        chk8("t5_mem_addr", mem_addr, 8'h05);
        chk8("t5_mem_din", mem_din, 8'h3C);
        idle(2);

        // Reset in the ACCESS cycle of an SPI read.
        spi(2'b10, 8'h12);
        spi(2'b11, 8'h00);
        tick();
        chk1("t6_in_access", mem_en, 1'b1);
        rst_n = 0;
        tick();
        chk1("t6_mem_en", mem_en, 1'b0);
        chk8("t6_mem_addr", mem_addr, 8'h00);
        chk1("t6_tx_valid", tx_valid, 1'b0);
        chk8("t6_tx_data", tx_data, 8'h00);
        chk1("t6_loc_rvalid", loc_rvalid, 1'b0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("t6_no_tx_pulse", tx_valid, 1'b0);
        end
        spi(2'b01, 8'h77);
        tick();
        chk8("t6_wr_addr_zero", mem_addr, 8'h00);
        idle(2);
        spi(2'b11, 8'hFF);
        tick();
        chk8("t6_rd_addr_zero", mem_addr, 8'h00);
        idle(3);

        // Randomized traffic on both ports with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 10'($urandom);
            rst_n    = ($urandom_range(0, 599) != 0);
            if (loc_gnt || !loc_req) begin
                loc_req   = ($urandom_range(0, 2) != 0);
                loc_we    = 1'($urandom);
                loc_addr  = 8'($urandom);
                loc_wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                loc_req = 0;
            end
            tick();
        end
        rx_valid = 0; loc_req = 0; rst_n = 1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave and the single-port RAM.
- Decodes the slave's 10-bit command words (bits [9:8] are the command, bits [7:0] the payload) and holds the write and read address registers.
- Shares the one RAM port between SPI traffic and a local requester port using round-robin arbitration.
- Returns read data to the SPI slave (tx_data/tx_valid) or to the local port.

Parameters:
- ADDR_SIZE, 8, RAM address width; equals the payload width of rx_data.
- MEM_DEPTH, 256, RAM depth; addresses at or above MEM_DEPTH are not range-checked, and the RAM aliases them.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- rx_data  in  10  SPI word: [9:8] cmd, [7:0] payload
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- tx_data  out  8  read data to SPI slave
- tx_valid  out  1  tx_data valid (level)
- spi_ovf  out  1  sticky: SPI RAM command dropped
- loc_req  in  1  local access request
- loc_we  in  1  local write (1) / read (0)
- loc_addr  in  ADDR_SIZE  local address
- loc_wdata  in  8  local write data
- loc_gnt  out  1  one-cycle grant
- loc_rvalid  out  1  one-cycle local read-data strobe
- loc_rdata  out  8  local read data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_SIZE  RAM address
- mem_din  out  8  RAM write data
- mem_dout  in  8  RAM read data, valid the cycle after a read access

Behaviour:
- Reset: every output is 0. wr_addr=0, rd_addr=0. Pending entry empty. State=IDLE. last_winner=LOC, so SPI wins the first tie.
- Command decode on rx_valid:
  - cmd 00: wr_addr<=payload. Applied immediately, even while an access is in flight. No RAM access.
  - cmd 10: rd_addr<=payload. Same rules as cmd 00.
  - cmd 01: enqueue SPI write {addr=wr_addr, data=payload}.
  - cmd 11: enqueue SPI read {addr=rd_addr}; the payload is ignored.
- The address is captured at enqueue time. Later address commands do not alter an already-pending entry.
- Pending entry is one deep.
  - A cmd 01/11 arriving while the entry is full is dropped and spi_ovf<=1.
  - spi_ovf stays set until reset.
  - The entry clears in the ACCESS cycle that serves it, so a same-cycle new command is accepted.
- Any rx_valid clears tx_valid.
- FSM states: IDLE, ACCESS, RD_RET.
- IDLE:
  - If exactly one of {pend, loc_req} is active, grant it.
  - If both are active, grant the side that is not last_winner.
  - On a grant: register mem_addr/mem_we/mem_din from the winner, set mem_en<=1, update last_winner, go to ACCESS.
  - With no request, stay in IDLE and hold mem_en=0.
- ACCESS (1 cycle):
  - mem_en=1.
  - loc_gnt=1 if the winner is LOC.
  - Write: go to IDLE. Read: go to RD_RET.
  - mem_en deasserts on the exit.
- RD_RET (1 cycle):
  - Capture mem_dout.
  - SPI winner: tx_data<=mem_dout, tx_valid<=1.
  - LOC winner: loc_rdata<=mem_dout, loc_rvalid<=1 for one cycle.
  - Go to IDLE.
- Latency from the IDLE decision cycle N:
  - RAM access at N+1.
  - Read data on tx_data/loc_rdata at N+3.
  - Next decision at N+2 after a write, N+3 after a read.
- Read-data hold:
  - tx_data holds its value until the next SPI read return.
  - tx_valid stays high until the next rx_valid, so the slave can shift the byte out.
  - loc_rdata holds until the next local read.
- Local handshake:
  - loc_addr/loc_we/loc_wdata are sampled in the IDLE decision cycle. The requester holds them, with loc_req, until loc_gnt.
  - Dropping loc_req before grant cancels the request with no access.
  - A loc_req still high in the cycle after loc_gnt is a new request.
- Reset mid-operation: the in-flight access is abandoned (mem_en=0 next cycle), the pending entry is dropped, and no tx_valid or loc_rvalid pulse is emitted.

Test Plan:
1. SPI write:
   - Stimulus: rx_data=00_0x12, then 01_0xA5; no loc_req.
   - Required: mem_en=mem_we=1, mem_addr=0x12, mem_din=0xA5 for exactly one cycle, two cycles after the 01 strobe.
2. SPI read:
   - Stimulus: preload RAM[0x12]=0xA5; rx_data=10_0x12, then 11_0x00.
   - Required: mem_we=0 access at 0x12. tx_data=0xA5 with tx_valid=1 three cycles after the enqueue decision. tx_valid stays high until the next rx_valid.
3. Contention:
   - Stimulus: SPI write pending and loc_req read @0x40 both active from reset.
   - Required: SPI is served first. loc_gnt follows in the next IDLE decision. loc_rvalid=1 with RAM[0x40]. The next tie goes to SPI.
4. Overflow:
   - Stimulus: hold loc_req continuously writing, so the pending entry is full; issue two back-to-back SPI 01 commands.
   - Required: the first is served. If the second arrives before the first is served, it is dropped and spi_ovf=1 remains until rst_n=0.
5. Address isolation:
   - Stimulus: enqueue 01 with wr_addr=0x05, then 00_0x07 before it is granted.
   - Required: the write goes to 0x05.
6. Reset mid-read:
   - Stimulus: assert rst_n=0 in the ACCESS cycle of an SPI read.
   - Required: all outputs are 0 next cycle, no tx_valid pulse, and wr_addr=rd_addr=0.
